assoc_cache: RTL and testbench
==============================

ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 The block SHALL expose parameter WAYS, default 2, number of ways per set (power of two, 1..8).
REQ-002 The block SHALL expose parameter SETS, default 64, number of sets (power of two).
REQ-003 The block SHALL expose parameter LINE_WORDS, default 8, 16-bit words per line (power of two, >=2).
REQ-004 The block SHALL have ports: clk  in  1  clock (one clock; reset is synchronous and active-high); rst  in  1  synchronous active-high reset.
REQ-005 The block SHALL have ports: req_valid in 1 request strobe; req_ready out 1 request accepted; req_we in 1 write request; req_addr in 16 byte address; req_wdata in 16 write data.
REQ-006 The block SHALL have ports: resp_valid out 1 response strobe; resp_rdata out 16 read data; resp_hit out 1 request hit.
REQ-007 The block SHALL have ports: mem_rd out 1 word read strobe; mem_we out 1 word write strobe; mem_addr out 16 word address; mem_wdata out 16 write data; mem_rvalid in 1 read data valid; mem_rdata in 16 read data.

Function
REQ-008 The block SHALL decode addresses as bit 0 ignored, offset = next log2(LINE_WORDS) bits, index = next log2(SETS) bits, tag = remaining upper bits.
REQ-009 The block SHALL implement FSM states IDLE, FILL, RESP. req_ready SHALL be 1 only in IDLE.
REQ-010 A request SHALL be accepted on a cycle with req_valid & req_ready (cycle T). Lookup SHALL compare the tag against all WAYS valid tags of the indexed set in cycle T.
REQ-011 On a read hit, the block SHALL assert resp_valid=1, resp_hit=1, resp_rdata=the hit word for exactly cycle T+1. The FSM SHALL stay in IDLE, so a new request is accepted in cycle T+1.
REQ-012 Writes SHALL be write-through and no-write-allocate.
REQ-013 For a write, in cycle T+1 the block SHALL pulse mem_we with mem_addr=req_addr and mem_wdata=req_wdata, and SHALL pulse resp_valid with resp_hit=hit. The memory accepts writes unconditionally.
REQ-014 On a write hit, the block SHALL update the cached word at T+1. On a write miss, cache contents SHALL be unchanged.
REQ-015 On a read miss, the block SHALL latch the address and move to FILL at T+1. The victim way SHALL be the lowest-index invalid way; if all ways are valid, it SHALL be the way given by the set's round-robin pointer.
REQ-016 In FILL, the block SHALL read words 0..LINE_WORDS-1 of the line in order, with one read outstanding at a time. It SHALL pulse mem_rd for one cycle per word and issue the next mem_rd in the cycle after each mem_rvalid.
REQ-017 Memory latency is arbitrary, with at least 1 cycle from mem_rd to mem_rvalid. Each mem_rvalid SHALL write mem_rdata into the victim way.
REQ-018 The victim line SHALL be invalid throughout FILL.
REQ-019 After the last mem_rvalid, the block SHALL write the tag, set valid, advance the set's round-robin pointer modulo WAYS if a valid line was evicted, and go to RESP.
REQ-020 In RESP, the block SHALL assert resp_valid=1, resp_hit=0, resp_rdata=the requested word for one cycle, then return to IDLE.
REQ-021 mem_rvalid SHALL be ignored outside FILL.
REQ-022 resp_rdata SHALL be 0 whenever resp_valid=0.
REQ-023 With WAYS=1, the block SHALL behave as direct-mapped and have no replacement state.

Reset
REQ-024 Reset SHALL clear all valid bits and round-robin pointers, force IDLE, and drive all outputs to 0, except req_ready, which SHALL be 1 in the first cycle after rst deasserts.
REQ-025 Reset during FILL SHALL abort the fill, leave the victim line invalid, and ignore any later mem_rvalid.
REQ-026 Data and tag arrays SHALL NOT be reset.

Configuration
REQ-027 With ASSOC_CACHE_STATS_EN defined, the block SHALL add outputs hit_count[15:0] and miss_count[15:0].
REQ-028 Each accepted request SHALL increment exactly one of hit_count or miss_count at T+1; both counters SHALL saturate at 16'hFFFF and clear on rst.
REQ-029 Without ASSOC_CACHE_STATS_EN, these ports and their logic SHALL be absent.

Verification
REQ-030 The bench SHALL cover: reset, then read 16'h0402 with memory returning k+1 for word k at 3-cycle latency -> 8 mem_rd to 16'h0400..16'h040E, resp_valid resp_hit=0 resp_rdata=2.
REQ-031 The bench SHALL cover: repeat read 16'h0402 -> resp_valid at T+1 resp_hit=1 rdata=2, and no mem_rd.
REQ-032 The bench SHALL cover: write 16'h0404 data 16'hBEEF (hit) -> mem_we at T+1 with addr 16'h0404, and a following read 16'h0404 hits and returns 16'hBEEF.
REQ-033 The bench SHALL cover, with WAYS=2: read miss on tags A, B, C of set 0 -> C evicts A; read of A misses; read of B hits.
REQ-034 The bench SHALL cover: rst asserted during the 4th FILL word -> req_ready=1 after reset, the late mem_rvalid is ignored, and a re-read of the same address misses.
REQ-035 The bench SHALL cover, with ASSOC_CACHE_STATS_EN: 3 hits and 2 misses -> hit_count=3, miss_count=2.

Source files
------------

// File: rtl/assoc_cache.sv
// Set-associative read-allocate / write-through cache with a blocking line fill.
// Optional hit/miss counters are enabled by defining ASSOC_CACHE_STATS_EN.
module assoc_cache #(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_hit,
    output logic        mem_rd,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata
`ifdef ASSOC_CACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);
    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 16 - 1 - OFF_W - IDX_W;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;
    state_t state, state_d;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [15:0]      data_q  [SETS][WAYS][LINE_WORDS];

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    assign req_off = req_addr[OFF_W:1];
    assign req_idx = req_addr[OFF_W+IDX_W:OFF_W+1];
    assign req_tag = req_addr[15:OFF_W+IDX_W+1];

    logic [TAG_W-1:0] lat_tag;
    logic [IDX_W-1:0] lat_idx;
    logic [OFF_W-1:0] lat_off, fill_cnt;
    logic [WAY_W-1:0] lat_way;
    logic             lat_evict;
    logic [15:0]      req_word;

    logic             accept, hit, fill_done;
    logic [WAY_W-1:0] hit_way, vic_way, rr_cur;
    logic             resp_valid_d, resp_hit_d, mem_rd_d, mem_we_d;
    logic [15:0]      resp_rdata_d, mem_addr_d, mem_wdata_d;

    assign accept    = req_valid && req_ready && (state == IDLE);
    assign fill_done = (state == FILL) && mem_rvalid && (fill_cnt == '1);

    // Tag lookup and victim choice: lowest invalid way, else round-robin pointer
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vic_way = rr_cur;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) vic_way = WAY_W'(w);
        end
    end

    generate
        if (WAYS > 1) begin : g_rr
            logic [WAY_W-1:0] rr_q [SETS];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
                end else if (fill_done && lat_evict) begin
                    rr_q[lat_idx] <= rr_q[lat_idx] + WAY_W'(1);
                end
            end
            assign rr_cur = rr_q[req_idx];
        end else begin : g_no_rr
            assign rr_cur = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d      = state;
        resp_valid_d = 1'b0;
        resp_hit_d   = 1'b0;
        resp_rdata_d = '0;
        mem_rd_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_we) begin
                        mem_we_d     = 1'b1;
                        mem_addr_d   = req_addr;
                        mem_wdata_d  = req_wdata;
                        resp_valid_d = 1'b1;
                        resp_hit_d   = hit;
                    end else if (hit) begin
                        resp_valid_d = 1'b1;
                        resp_hit_d   = 1'b1;
                        resp_rdata_d = data_q[req_idx][hit_way][req_off];
                    end else begin
                        state_d    = FILL;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = {req_tag, req_idx, OFF_W'(0), 1'b0};
                    end
                end
            end
            FILL: begin
                if (mem_rvalid) begin
                    if (fill_cnt == '1) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = (fill_cnt == lat_off) ? mem_rdata : req_word;
                    end else begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = {lat_tag, lat_idx, fill_cnt + OFF_W'(1), 1'b0};
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs, fill bookkeeping and valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_rdata <= '0;
            mem_rd     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            lat_tag    <= '0;
            lat_idx    <= '0;
            lat_off    <= '0;
            lat_way    <= '0;
            lat_evict  <= 1'b0;
            fill_cnt   <= '0;
            req_word   <= '0;
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else begin
            req_ready  <= (state_d == IDLE);
            resp_valid <= resp_valid_d;
            resp_hit   <= resp_hit_d;
            resp_rdata <= resp_rdata_d;
            mem_rd     <= mem_rd_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            if (accept && !req_we && !hit) begin
                lat_tag                   <= req_tag;
                lat_idx                   <= req_idx;
                lat_off                   <= req_off;
                lat_way                   <= vic_way;
                lat_evict                 <= &valid_q[req_idx];
                fill_cnt                  <= '0;
                valid_q[req_idx][vic_way] <= 1'b0;
            end
            if ((state == FILL) && mem_rvalid) begin
                fill_cnt <= fill_cnt + OFF_W'(1);
                if (fill_cnt == lat_off) req_word <= mem_rdata;
            end
            if (fill_done) valid_q[lat_idx][lat_way] <= 1'b1;
        end
    end

    // Line storage keeps its contents across reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept && req_we && hit) data_q[req_idx][hit_way][req_off] <= req_wdata;
            if ((state == FILL) && mem_rvalid) data_q[lat_idx][lat_way][fill_cnt] <= mem_rdata;
            if (fill_done) tag_q[lat_idx][lat_way] <= lat_tag;
        end
    end

`ifdef ASSOC_CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (hit) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache (default WAYS=2, SETS=64, LINE_WORDS=8) with a 3-cycle memory model.
// Define ASSOC_CACHE_STATS_EN to also exercise the hit/miss counters.
module tb_assoc_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic        req_ready;
    logic [15:0] req_addr, req_wdata;
    logic        resp_valid, resp_hit;
    logic [15:0] resp_rdata;
    logic        mem_rd, mem_we, mem_rvalid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ASSOC_CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int rd_count = 0;
    logic [15:0] rd_log [64];

    assoc_cache dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef ASSOC_CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Memory: word k of a line returns (k+1) | ((tag ^ 1) << 8), 3 cycles after mem_rd
    initial begin
        int cnt;
        logic [15:0] val;
        logic [15:0] a;
        cnt = 0;
        val = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = val;
                end
            end
            if (mem_rd === 1'b1) begin
                a   = mem_addr;
                val = 16'({13'd0, a[3:1]} + 16'd1) | 16'({2'd0, a[15:10] ^ 6'd1, 8'd0});
                cnt = 3;
                if (rd_count < 64) rd_log[rd_count] = a;
                rd_count = rd_count + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Present one request; returns positioned in cycle T+1
    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wd);
        for (int i = 0; i < 200 && req_ready !== 1'b1; i++) step();
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic wait_resp(output bit got);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (resp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++;
        if ({req_ready, resp_valid, resp_hit, mem_rd, mem_we} !== 5'b10000) $display("FAIL reset_ctrl got %b want 10000", {req_ready, resp_valid, resp_hit, mem_rd, mem_we});
        else pass_cnt++;
        chk_cnt++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 48'd0) $display("FAIL reset_data got %h want 0", {resp_rdata, mem_addr, mem_wdata});
        else pass_cnt++;
    endtask

    task automatic test_read_miss();
        bit got;
        int bad;
        rd_count = 0;
        issue(1'b0, 16'h0402, 16'h0);
        chk_cnt++;
        if ({resp_valid, mem_rd, mem_addr} !== {2'b01, 16'h0400}) $display("FAIL miss_first_rd got %b/%b/%h want 0/1/0400", resp_valid, mem_rd, mem_addr);
        else pass_cnt++;
        wait_resp(got);
        chk_cnt++;
        if ({got, resp_hit, resp_rdata} !== {2'b10, 16'd2}) $display("FAIL miss_resp got %b/%b/%h want 1/0/0002", got, resp_hit, resp_rdata);
        else pass_cnt++;
        bad = 0;
        for (int k = 0; k < 8; k++) if (rd_log[k] !== 16'(16'h0400 + 2 * k)) bad++;
        chk_cnt++;
        if (rd_count != 8 || bad != 0) $display("FAIL miss_rd_seq got count %0d bad %0d want 8/0", rd_count, bad);
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({req_ready, resp_valid, resp_rdata} !== {2'b10, 16'd0}) $display("FAIL miss_after got %b/%b/%h want 1/0/0000", req_ready, resp_valid, resp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_read_hit();
        rd_count = 0;
        issue(1'b0, 16'h0402, 16'h0);
        chk_cnt++;
        if ({resp_valid, resp_hit, resp_rdata, req_ready} !== {2'b11, 16'd2, 1'b1}) $display("FAIL hit_resp got %b/%b/%h/%b want 1/1/0002/1", resp_valid, resp_hit, resp_rdata, req_ready);
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({resp_valid, resp_rdata} !== 17'd0) $display("FAIL hit_after got %b/%h want 0/0000", resp_valid, resp_rdata);
        else pass_cnt++;
        repeat (5) step();
        chk_cnt++;
        if (rd_count != 0) $display("FAIL hit_no_rd got %0d want 0", rd_count);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back_write();
        bit got;
        issue(1'b1, 16'h0404, 16'hBEEF);
        chk_cnt++;
        if ({mem_we, mem_addr, mem_wdata, resp_valid, resp_hit} !== {1'b1, 16'h0404, 16'hBEEF, 2'b11}) $display("FAIL wr_hit got %b/%h/%h/%b/%b want 1/0404/beef/1/1", mem_we, mem_addr, mem_wdata, resp_valid, resp_hit);
        else pass_cnt++;
        issue(1'b0, 16'h0404, 16'h0);
        chk_cnt++;
        if ({resp_valid, resp_hit, resp_rdata} !== {2'b11, 16'hBEEF}) $display("FAIL wr_readback got %b/%b/%h want 1/1/beef", resp_valid, resp_hit, resp_rdata);
        else pass_cnt++;
        issue(1'b1, 16'h3000, 16'h1234);
        chk_cnt++;
        if ({mem_we, mem_addr, mem_wdata, resp_valid, resp_hit} !== {1'b1, 16'h3000, 16'h1234, 2'b10}) $display("FAIL wr_miss got %b/%h/%h/%b/%b want 1/3000/1234/1/0", mem_we, mem_addr, mem_wdata, resp_valid, resp_hit);
        else pass_cnt++;
        issue(1'b0, 16'h3000, 16'h0);
        chk_cnt++;
        if ({resp_valid, mem_rd} !== 2'b01) $display("FAIL wr_no_alloc got %b/%b want 0/1", resp_valid, mem_rd);
        else pass_cnt++;
        wait_resp(got);
        chk_cnt++;
        if ({got, resp_hit, resp_rdata} !== {2'b10, 16'h0D01}) $display("FAIL wr_no_alloc_fill got %b/%b/%h want 1/0/0d01", got, resp_hit, resp_rdata);
        else pass_cnt++;
        step();
    endtask

    task automatic test_replacement();
        bit got;
        do_reset();
        issue(1'b0, 16'h0800, 16'h0); wait_resp(got); step();
        issue(1'b0, 16'h0C00, 16'h0); wait_resp(got); step();
        issue(1'b0, 16'h1000, 16'h0); wait_resp(got);
        chk_cnt++;
        if ({got, resp_hit, resp_rdata} !== {2'b10, 16'h0501}) $display("FAIL repl_c got %b/%b/%h want 1/0/0501", got, resp_hit, resp_rdata);
        else pass_cnt++;
        step();
        issue(1'b0, 16'h1000, 16'h0);
        chk_cnt++;
        if ({resp_valid, resp_hit, resp_rdata} !== {2'b11, 16'h0501}) $display("FAIL repl_c_hit got %b/%b/%h want 1/1/0501", resp_valid, resp_hit, resp_rdata);
        else pass_cnt++;
        issue(1'b0, 16'h0C00, 16'h0);
        chk_cnt++;
        if ({resp_valid, resp_hit, resp_rdata} !== {2'b11, 16'h0201}) $display("FAIL repl_b_hit got %b/%b/%h want 1/1/0201", resp_valid, resp_hit, resp_rdata);
        else pass_cnt++;
        issue(1'b0, 16'h0800, 16'h0);
        chk_cnt++;
        if ({resp_valid, mem_rd} !== 2'b01) $display("FAIL repl_a_miss got %b/%b want 0/1", resp_valid, mem_rd);
        else pass_cnt++;
        wait_resp(got);
        chk_cnt++;
        if ({got, resp_hit, resp_rdata} !== {2'b10, 16'h0301}) $display("FAIL repl_a_fill got %b/%b/%h want 1/0/0301", got, resp_hit, resp_rdata);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_during_fill();
        bit got;
        int seen;
        rd_count = 0;
        issue(1'b0, 16'h2000, 16'h0);
        for (int i = 0; i < 100 && rd_count < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_cnt++;
        if ({req_ready, resp_valid, mem_rd} !== 3'b100) $display("FAIL rst_fill_ready got %b want 100", {req_ready, resp_valid, mem_rd});
        else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid !== 1'b0 || mem_rd !== 1'b0) seen++;
            step();
        end
        chk_cnt++;
        if (seen != 0 || rd_count != 4) $display("FAIL rst_fill_late got %0d/%0d want 0/4", seen, rd_count);
        else pass_cnt++;
        issue(1'b0, 16'h2000, 16'h0);
        chk_cnt++;
        if ({resp_valid, mem_rd, mem_addr} !== {2'b01, 16'h2000}) $display("FAIL rst_fill_reread got %b/%b/%h want 0/1/2000", resp_valid, mem_rd, mem_addr);
        else pass_cnt++;
        wait_resp(got);
        chk_cnt++;
        if ({got, resp_hit, resp_rdata} !== {2'b10, 16'h0901}) $display("FAIL rst_fill_resp got %b/%b/%h want 1/0/0901", got, resp_hit, resp_rdata);
        else pass_cnt++;
        step();
    endtask

`ifdef ASSOC_CACHE_STATS_EN
    task automatic test_stats();
        bit got;
        do_reset();
        chk_cnt++;
        if ({hit_count, miss_count} !== 32'd0) $display("FAIL stats_reset got %h/%h want 0/0", hit_count, miss_count);
        else pass_cnt++;
        issue(1'b0, 16'h0402, 16'h0); wait_resp(got); step();
        issue(1'b0, 16'h0402, 16'h0);
        issue(1'b0, 16'h0402, 16'h0);
        issue(1'b1, 16'h0404, 16'h5555);
        issue(1'b0, 16'h0800, 16'h0); wait_resp(got); step();
        chk_cnt++;
        if ({hit_count, miss_count} !== {16'd3, 16'd2}) $display("FAIL stats_count got %0d/%0d want 3/2", hit_count, miss_count);
        else pass_cnt++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_back_to_back_write();
        test_replacement();
        test_reset_during_fill();
`ifdef ASSOC_CACHE_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
